// File: rtl/pusch_tx_sample_buffer.sv
// pusch_tx_sample_buffer
// Scales the IFFT/CP complex sample stream by an arithmetic right shift,
// saturates each component to the DAC word width and buffers the result in a
// first-word-fall-through FIFO. A small IDLE/STREAM state machine primes the
// FIFO at burst start so the RF front end sees a gap-free burst.
// Optional feature macro: PUSCH_TX_ROUND_EN (round half up before saturation).
module pusch_tx_sample_buffer #(
   parameter int IN_WIDTH    = 26,
   parameter int OUT_WIDTH   = 16,
   parameter int SHIFT       = 8,
   parameter int DEPTH       = 16,
   parameter int PRIME_LEVEL = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [IN_WIDTH-1:0]      in_r,
   input  logic [IN_WIDTH-1:0]      in_i,
   input  logic                     in_valid,
   input  logic                     out_ready,
   output logic [OUT_WIDTH-1:0]     out_r,
   output logic [OUT_WIDTH-1:0]     out_i,
   output logic                     out_valid,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     sat_pulse,
   output logic                     overflow,
   output logic                     burst_done
);

   localparam int AW = $clog2(DEPTH);
   // One extra bit so the rounding addition can never wrap.
   localparam int SW = IN_WIDTH + 1;

   localparam logic signed [SW-1:0] SAT_MAX = SW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

   localparam logic [AW:0] PRIME_FILL = (AW + 1)'(PRIME_LEVEL);
   localparam logic [AW:0] DEPTH_FILL = (AW + 1)'(DEPTH);

`ifdef PUSCH_TX_ROUND_EN
   // Half an output LSB; zero when no shift is applied (nothing to round).
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [SW-1:0] HALF_LSB = (SHIFT > 0) ? (SW'(1) << RND_POS) : '0;
`endif

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Component 0 is real, component 1 is imaginary.
   logic signed [IN_WIDTH-1:0] comp_in [2];
   logic [OUT_WIDTH-1:0]       scaled [2];
   logic [1:0]                 sat_hi;
   logic [1:0]                 sat_lo;

   logic                       stage_valid_reg;
   logic [OUT_WIDTH-1:0]       stage_r_reg;
   logic [OUT_WIDTH-1:0]       stage_i_reg;
   logic                       stage_sat_reg;

   logic [2*OUT_WIDTH-1:0]     mem [DEPTH];
   logic [AW-1:0]              wr_ptr_reg;
   logic [AW-1:0]              rd_ptr_reg;
   logic [AW:0]                fill_reg;
   logic [AW:0]                fill_next;
   logic                       overflow_reg;
   logic                       sat_pulse_reg;
   logic                       burst_done_reg;

   state_t                     state_reg;
   state_t                     state_next;
   logic                       out_valid_c;

   logic                       in_take;
   logic                       full;
   logic                       rd_fire;
   logic                       wr_en;
   logic [2*OUT_WIDTH-1:0]     head;

   assign comp_in[0] = in_r;
   assign comp_in[1] = in_i;
   assign in_take    = in_valid && enable;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_comp
         logic signed [SW-1:0] ext;
         logic signed [SW-1:0] rnd;
         logic signed [SW-1:0] shf;

         assign ext = {comp_in[gi][IN_WIDTH-1], comp_in[gi]};
`ifdef PUSCH_TX_ROUND_EN
         assign rnd = ext + HALF_LSB;
`else
         assign rnd = ext;
`endif
         assign shf        = rnd >>> SHIFT;
         assign sat_hi[gi] = (shf > SAT_MAX);
         assign sat_lo[gi] = (shf < SAT_MIN);
         assign scaled[gi] = sat_hi[gi] ? OUT_MAX :
                             (sat_lo[gi] ? OUT_MIN : shf[OUT_WIDTH-1:0]);
      end
   endgenerate

   // Stage 1: capture the scaled, saturated sample and its saturation flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_valid_reg <= 1'b0;
         stage_r_reg     <= '0;
         stage_i_reg     <= '0;
         stage_sat_reg   <= 1'b0;
      end else begin
         stage_valid_reg <= in_take;
         if (in_take) begin
            stage_r_reg   <= scaled[0];
            stage_i_reg   <= scaled[1];
            stage_sat_reg <= (|sat_hi) || (|sat_lo);
         end
      end
   end

   assign full    = (fill_reg == DEPTH_FILL);
   assign rd_fire = out_valid_c && out_ready;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign wr_en   = stage_valid_reg && (!full || rd_fire);

   always_comb begin
      fill_next = fill_reg;
      case ({wr_en, rd_fire})
         2'b10:   fill_next = fill_reg + 1'b1;
         2'b01:   fill_next = fill_reg - 1'b1;
         default: fill_next = fill_reg;
      endcase
   end

   // Sample storage; contents need no reset because pointers gate visibility.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= {stage_r_reg, stage_i_reg};
      end
   end

   // Stage 2: pointers, occupancy, sticky overflow and the saturation pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         fill_reg      <= '0;
         overflow_reg  <= 1'b0;
         sat_pulse_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         fill_reg      <= fill_next;
         overflow_reg  <= overflow_reg || (stage_valid_reg && full && !rd_fire);
         sat_pulse_reg <= stage_valid_reg && stage_sat_reg;
      end
   end

   // Burst state register and end-of-burst pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         burst_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         burst_done_reg <= (state_reg == STREAM) && (fill_reg == '0);
      end
   end

   // Priming / flush decisions and output qualification.
   always_comb begin
      state_next  = state_reg;
      out_valid_c = 1'b0;
      case (state_reg)
         IDLE: begin
            // Start once primed, or flush a short burst once nothing more is coming.
            if ((fill_reg >= PRIME_FILL) ||
                (!stage_valid_reg && !in_take && (fill_reg != '0))) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            out_valid_c = (fill_reg != '0);
            if (fill_reg == '0) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign head       = mem[rd_ptr_reg];
   assign out_valid  = out_valid_c;
   // Outputs read as zero whenever no sample is being offered.
   assign out_r      = out_valid_c ? head[2*OUT_WIDTH-1:OUT_WIDTH] : '0;
   assign out_i      = out_valid_c ? head[OUT_WIDTH-1:0] : '0;
   assign fill_level = fill_reg;
   assign sat_pulse  = sat_pulse_reg;
   assign overflow   = overflow_reg;
   assign burst_done = burst_done_reg;

endmodule

// File: tb/tb_pusch_tx_sample_buffer.sv
// Directed testbench for pusch_tx_sample_buffer (default parameters).
module tb_pusch_tx_sample_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [25:0] in_r;
   logic [25:0] in_i;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] out_r;
   logic [15:0] out_i;
   logic        out_valid;
   logic [4:0]  fill_level;
   logic        sat_pulse;
   logic        overflow;
   logic        burst_done;

   int n_cmp = 0;
   int n_bad = 0;

   pusch_tx_sample_buffer dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_r       (in_r),
      .in_i       (in_i),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .out_r      (out_r),
      .out_i      (out_i),
      .out_valid  (out_valid),
      .fill_level (fill_level),
      .sat_pulse  (sat_pulse),
      .overflow   (overflow),
      .burst_done (burst_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b1; in_r = '0; in_i = '0; in_valid = 1'b0; out_ready = 1'b0;
      tick; tick;
      n_cmp++;
      if ({out_valid, out_r, out_i, fill_level, sat_pulse, overflow, burst_done} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: valid=%b r=%0d i=%0d fill=%0d sat=%b ovf=%b bd=%b, required all 0",
                  out_valid, out_r, out_i, fill_level, sat_pulse, overflow, burst_done);
      end
      reset = 1'b0;
      tick;
      $display("reset: outputs checked");
   endtask

   task automatic test_scaling;
      out_ready = 1'b1;
      in_r = 26'(25600); in_i = 26'(-25600); in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      n_cmp++;
      if (sat_pulse !== 1'b0 || fill_level !== 5'd1) begin
         n_bad++;
         $display("FAIL scale_write: sat=%b fill=%0d, required sat=0 fill=1", sat_pulse, fill_level);
      end
      tick;
      n_cmp++;
      if (out_valid !== 1'b1 || out_r !== 16'(100) || out_i !== 16'(-100)) begin
         n_bad++;
         $display("FAIL scale_out: valid=%b r=%0d i=%0d, required 1/100/-100",
                  out_valid, $signed(out_r), $signed(out_i));
      end
      tick;
      n_cmp++;
      if (out_valid !== 1'b0 || fill_level !== 5'd0 || burst_done !== 1'b0) begin
         n_bad++;
         $display("FAIL scale_drain: valid=%b fill=%0d bd=%b, required 0/0/0", out_valid, fill_level, burst_done);
      end
      tick;
      n_cmp++;
      if (burst_done !== 1'b1) begin
         n_bad++;
         $display("FAIL scale_burst_done: bd=%b, required 1", burst_done);
      end
      tick;
      n_cmp++;
      if (burst_done !== 1'b0) begin
         n_bad++;
         $display("FAIL scale_burst_done_width: bd=%b, required 0", burst_done);
      end
      $display("scaling: 25600/-25600 -> %0d/%0d expected 100/-100", $signed(out_r), $signed(out_i));
   endtask

   task automatic test_saturation;
      out_ready = 1'b1;
      in_r = 26'(33554431); in_i = 26'(-33554432); in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      n_cmp++;
      if (sat_pulse !== 1'b1) begin
         n_bad++;
         $display("FAIL sat_pulse_high: sat=%b, required 1", sat_pulse);
      end
      tick;
      n_cmp++;
      if (sat_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL sat_pulse_width: sat=%b, required 0", sat_pulse);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_r !== 16'h7FFF || out_i !== 16'h8000) begin
         n_bad++;
         $display("FAIL sat_out: valid=%b r=%0d i=%0d, required 1/32767/-32768",
                  out_valid, $signed(out_r), $signed(out_i));
      end
      $display("saturation: out %0d/%0d", $signed(out_r), $signed(out_i));
      tick; tick; tick;
   endtask

   task automatic test_rounding;
      logic [15:0] exp_r;
      logic [15:0] exp_i;
`ifdef PUSCH_TX_ROUND_EN
      exp_r = 16'(2);  exp_i = 16'(-1);
`else
      exp_r = 16'(1);  exp_i = 16'(-2);
`endif
      out_ready = 1'b1;
      in_r = 26'(384); in_i = 26'(-384); in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      n_cmp++;
      if (out_valid !== 1'b1 || out_r !== exp_r || out_i !== exp_i) begin
         n_bad++;
         $display("FAIL round_out: valid=%b r=%0d i=%0d, required 1/%0d/%0d",
                  out_valid, $signed(out_r), $signed(out_i), $signed(exp_r), $signed(exp_i));
      end
      $display("rounding: 384/-384 -> %0d/%0d", $signed(out_r), $signed(out_i));
      tick; tick; tick;
   endtask

   task automatic test_enable_gate;
      out_ready = 1'b1;
      enable = 1'b0;
      in_r = 26'(1000); in_i = 26'(1000); in_valid = 1'b1;
      tick; tick; tick;
      in_valid = 1'b0;
      tick; tick;
      n_cmp++;
      if (fill_level !== 5'd0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL enable_gate: fill=%0d valid=%b, required 0/0", fill_level, out_valid);
      end
      enable = 1'b1;
      $display("enable gate: fill=%0d with enable low", fill_level);
   endtask

   task automatic test_priming;
      int  rd_cnt = 0;
      int  bd_cnt = 0;
      int  gaps = 0;
      int  prev_fill = 0;
      logic started = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (c < 20) begin
            in_valid = 1'b1;
            in_r = 26'((c + 1) * 256);
            in_i = 26'(-(c + 1) * 256);
         end else begin
            in_valid = 1'b0;
         end
         tick;
         if (out_valid === 1'b1) begin
            if (!started) begin
               started = 1'b1;
               n_cmp++;
               if (prev_fill != 8) begin
                  n_bad++;
                  $display("FAIL prime_level: fill before start=%0d, required 8", prev_fill);
               end
            end
            n_cmp++;
            if (out_r !== 16'(rd_cnt + 1) || out_i !== 16'(-(rd_cnt + 1))) begin
               n_bad++;
               $display("FAIL prime_data: r=%0d i=%0d, required %0d/%0d",
                        $signed(out_r), $signed(out_i), rd_cnt + 1, -(rd_cnt + 1));
            end
            rd_cnt++;
         end else if (started && rd_cnt < 20) begin
            gaps++;
         end
         if (burst_done === 1'b1) bd_cnt++;
         prev_fill = int'(fill_level);
      end
      n_cmp++;
      if (rd_cnt != 20 || gaps != 0 || bd_cnt != 1) begin
         n_bad++;
         $display("FAIL prime_burst: reads=%0d gaps=%0d burst_done=%0d, required 20/0/1", rd_cnt, gaps, bd_cnt);
      end
      n_cmp++;
      if (out_valid !== 1'b0 || fill_level !== 5'd0) begin
         n_bad++;
         $display("FAIL prime_idle: valid=%b fill=%0d, required 0/0", out_valid, fill_level);
      end
      $display("priming: reads=%0d gaps=%0d burst_done pulses=%0d", rd_cnt, gaps, bd_cnt);
   endtask

   task automatic test_overflow;
      int exp_k;
      out_ready = 1'b0;
      for (int c = 0; c < 18; c++) begin
         in_valid = 1'b1;
         in_r = 26'((c + 1) * 256);
         in_i = 26'(-(c + 1) * 256);
         tick;
         if (c == 16) begin
            n_cmp++;
            if (fill_level !== 5'd16 || overflow !== 1'b0) begin
               n_bad++;
               $display("FAIL ovf_just_full: fill=%0d ovf=%b, required 16/0", fill_level, overflow);
            end
         end
      end
      in_valid = 1'b0;
      tick; tick; tick;
      n_cmp++;
      if (fill_level !== 5'd16 || overflow !== 1'b1 || out_valid !== 1'b1 || out_r !== 16'(1)) begin
         n_bad++;
         $display("FAIL ovf_full: fill=%0d ovf=%b valid=%b head=%0d, required 16/1/1/1",
                  fill_level, overflow, out_valid, $signed(out_r));
      end
      // Write and read on the same edge while full.
      in_valid = 1'b1; in_r = 26'(99 * 256); in_i = 26'(-99 * 256);
      tick;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      n_cmp++;
      if (fill_level !== 5'd16 || out_r !== 16'(2)) begin
         n_bad++;
         $display("FAIL ovf_rw_full: fill=%0d head=%0d, required 16/2", fill_level, $signed(out_r));
      end
      out_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         exp_k = (j < 15) ? j + 2 : 99;
         n_cmp++;
         if (out_valid !== 1'b1 || out_r !== 16'(exp_k) || out_i !== 16'(-exp_k)) begin
            n_bad++;
            $display("FAIL ovf_readout: idx=%0d valid=%b r=%0d i=%0d, required 1/%0d/%0d",
                     j, out_valid, $signed(out_r), $signed(out_i), exp_k, -exp_k);
         end
         tick;
      end
      n_cmp++;
      if (fill_level !== 5'd0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_empty: fill=%0d valid=%b, required 0/0", fill_level, out_valid);
      end
      $display("overflow: sticky=%b after readout", overflow);
      tick; tick; tick;
   endtask

   task automatic test_reset_mid_burst;
      int rd_cnt = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_r = 26'((c + 1) * 256);
         in_i = 26'(-(c + 1) * 256);
         tick;
      end
      in_valid = 1'b0;
      tick; tick; tick;
      n_cmp++;
      if (fill_level !== 5'd5 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_pre: fill=%0d valid=%b, required 5/1", fill_level, out_valid);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || fill_level !== 5'd0 || overflow !== 1'b0 || out_r !== 16'd0) begin
         n_bad++;
         $display("FAIL rst_async: valid=%b fill=%0d ovf=%b r=%0d, required 0/0/0/0",
                  out_valid, fill_level, overflow, out_r);
      end
      reset = 1'b0;
      tick;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c < 3) begin
            in_valid = 1'b1;
            in_r = 26'((c + 7) * 256);
            in_i = 26'(-(c + 7) * 256);
         end else begin
            in_valid = 1'b0;
         end
         tick;
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (out_r !== 16'(rd_cnt + 7) || out_i !== 16'(-(rd_cnt + 7))) begin
               n_bad++;
               $display("FAIL flush_data: r=%0d i=%0d, required %0d/%0d",
                        $signed(out_r), $signed(out_i), rd_cnt + 7, -(rd_cnt + 7));
            end
            rd_cnt++;
         end
      end
      n_cmp++;
      if (rd_cnt != 3 || fill_level !== 5'd0) begin
         n_bad++;
         $display("FAIL flush_count: reads=%0d fill=%0d, required 3/0", rd_cnt, fill_level);
      end
      $display("reset mid-burst: flushed %0d samples after reset", rd_cnt);
   endtask

   initial begin
      test_reset;
      test_scaling;
      test_saturation;
      test_rounding;
      test_enable_gate;
      test_priming;
      test_overflow;
      test_reset_mid_burst;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pusch_tx_sample_buffer.md
Name: pusch_tx_sample_buffer

Overview:
- Downstream of the PUSCH transmit chain; consumes the IFFT/CP complex sample stream (Data_r/Data_i/Data_valid).
- Scales each sample by arithmetic right shift, saturates it to the RF/DAC word width and buffers it in a FIFO.
- Releases samples over a valid/ready handshake, with start-of-burst priming so the RF front end never sees mid-burst gaps caused by pipeline jitter.

Parameters:
- IN_WIDTH, 26, signed input sample width (matches IFFT output width)
- OUT_WIDTH, 16, signed output sample width
- SHIFT, 8, arithmetic right-shift amount applied before saturation (0..IN_WIDTH-2)
- DEPTH, 16, FIFO depth in complex samples; power of two, >=4
- PRIME_LEVEL, 8, FIFO fill required before output starts at burst start (1..DEPTH)

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  input accept enable; output drain is unaffected
- in_r  in  IN_WIDTH  signed real input sample
- in_i  in  IN_WIDTH  signed imaginary input sample
- in_valid  in  1  input sample qualifier; no backpressure upstream
- out_ready  in  1  downstream accepts sample this cycle
- out_r  out  OUT_WIDTH  signed real output, FIFO head
- out_i  out  OUT_WIDTH  signed imaginary output, FIFO head
- out_valid  out  1  out_r/out_i valid
- fill_level  out  log2(DEPTH)+1  current FIFO occupancy
- sat_pulse  out  1  one-cycle pulse: the sample just written had real or imaginary saturated
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- burst_done  out  1  one-cycle pulse on STREAM->IDLE

Behaviour:
- Reset (asynchronous): FIFO pointers 0, fill_level 0, state IDLE, stage register invalid. All outputs 0: out_r, out_i, out_valid, sat_pulse, overflow, burst_done.
- Stage 1 (scale):
  - On an edge where in_valid&&enable, register y = x >>> SHIFT for each component (arithmetic shift, floor toward -inf).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Record a per-sample sat flag = real OR imaginary saturated.
  - When enable=0, in_valid is ignored and the stage is marked invalid.
- Stage 2 (write): on the next edge, a valid stage sample is written to the FIFO.
  - sat_pulse is asserted for exactly the cycle following that write edge, whether or not the write was accepted.
- Full:
  - A write with FIFO full and no simultaneous read is dropped; overflow sets and holds until reset.
  - A write and a read on the same edge while full are both performed; fill_level is unchanged and no overflow.
- Read:
  - A transfer occurs on an edge where out_valid&&out_ready.
  - out_r/out_i show the FIFO head combinationally from registered storage (first-word fall-through).
  - out_r/out_i hold their value while out_valid&&!out_ready.
- Pointers: log2(DEPTH) bits, wrap naturally; fill_level = writes - reads, range 0..DEPTH.
- State machine:
  - IDLE: out_valid=0. Go to STREAM when fill_level >= PRIME_LEVEL, or when the stage is empty, in_valid=0 and fill_level>0 (flushes a short burst).
  - STREAM: out_valid = (fill_level>0). Go to IDLE when fill_level reaches 0; burst_done pulses for 1 cycle.
- Latency: in_valid sampled at edge k -> FIFO write at edge k+1 -> fill_level updates after k+1. With PRIME_LEVEL=1 from IDLE, out_valid is high after edge k+2 (state update).
- Reset mid-burst: all contents are discarded immediately and out_valid drops asynchronously.

Optional Feature:
- Macro: PUSCH_TX_ROUND_EN.
- Defined: stage 1 computes (x + 2^(SHIFT-1)) >>> SHIFT, round half up, before saturation. The addition is performed at IN_WIDTH+1 bits so it cannot wrap. When SHIFT=0, no rounding is applied.
- Undefined: truncation (floor) as described above.

Test Plan:
- Scaling, SHIFT=8: in_r=25600, in_i=-25600 -> out_r=100, out_i=-100, sat_pulse=0.
- Saturation: in_r=33554431, in_i=-33554432 -> out_r=32767, out_i=-32768, sat_pulse=1 for one cycle.
- Rounding: in_r=384, in_i=-384 -> without macro 1/-2; with PUSCH_TX_ROUND_EN 2/-1.
- Priming, PRIME_LEVEL=8, out_ready=1: 20 consecutive samples -> out_valid stays 0 until fill_level=8, then 20 samples in order with no gap, then burst_done pulses once and state returns to IDLE.
- Overflow, DEPTH=16, out_ready=0: 18 samples -> fill_level=16, overflow=1, first 16 samples read out intact. Then with fill=16, one write plus one read on the same edge -> fill stays 16, no drop.
- Reset mid-burst: assert reset with fill_level=5 -> out_valid=0, fill_level=0, overflow=0 immediately. A new 3-sample burst then flushes out via the idle-flush path.
